// File: rtl/instruction_fetch_stage.sv
// Purpose : PC register and IF/ID pipeline register feeding a combinational instruction memory.
// Latency : inst_addr is combinational from pc; the word at pc lands in IF/ID on the next rising edge.
// Backpr. : stall holds pc, IF/ID and count; a branch overrides stall; a misaligned target halts until reset.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   stall               hold pc and IF/ID this cycle
//   branch_taken/target redirect request and its byte address
//   inst_addr           byte address to instruction memory (= pc)
//   inst_data           instruction word returned for inst_addr
//   if_id_pc/inst/valid IF/ID register contents
//   misaligned          sticky fault: a redirect target was not word aligned
//   fetch_count         saturating count of instructions delivered into IF/ID
module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [63:0]      branch_target,
   output logic [63:0]      inst_addr,
   input  logic [31:0]      inst_data,
   output logic [63:0]      if_id_pc,
   output logic [31:0]      if_id_inst,
   output logic             if_id_valid,
   output logic             misaligned,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t           state_q, state_d;
   logic [63:0]      pc_q, pc_d;
   logic [63:0]      if_id_pc_q, if_id_pc_d;
   logic [31:0]      if_id_inst_q, if_id_inst_d;
   logic             if_id_valid_q, if_id_valid_d;
   logic             misaligned_q, misaligned_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      if_id_pc_d    = if_id_pc_q;
      if_id_inst_d  = if_id_inst_q;
      if_id_valid_d = if_id_valid_q;
      misaligned_d  = misaligned_q;
      cnt_d         = cnt_q;

      case (state_q)
         ST_RUN: begin
            if (branch_taken) begin
               // The wrong-path instruction is discarded whatever the target.
               if_id_pc_d    = 64'h0;
               if_id_inst_d  = NOP_INST;
               if_id_valid_d = 1'b0;
               if (branch_target[1:0] != 2'b00) begin
                  misaligned_d = 1'b1;
                  state_d      = ST_HALT;
               end else begin
                  pc_d = branch_target;
               end
            end else if (!stall) begin
               if_id_pc_d    = pc_q;
               if_id_inst_d  = inst_data;
               if_id_valid_d = 1'b1;
               pc_d          = pc_q + 64'd4;  // wraps modulo 2^64 by design
               if (!(&cnt_q)) begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
         end
         ST_HALT: begin
            // Frozen until reset; keep a bubble in IF/ID.
            if_id_pc_d    = 64'h0;
            if_id_inst_d  = NOP_INST;
            if_id_valid_d = 1'b0;
            misaligned_d  = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_RUN;
         pc_q          <= RESET_PC;
         if_id_pc_q    <= 64'h0;
         if_id_inst_q  <= NOP_INST;
         if_id_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         if_id_pc_q    <= if_id_pc_d;
         if_id_inst_q  <= if_id_inst_d;
         if_id_valid_q <= if_id_valid_d;
         misaligned_q  <= misaligned_d;
         cnt_q         <= cnt_d;
      end
   end

   assign inst_addr   = pc_q;
   assign if_id_pc    = if_id_pc_q;
   assign if_id_inst  = if_id_inst_q;
   assign if_id_valid = if_id_valid_q;
   assign misaligned  = misaligned_q;
   assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
module tb_instruction_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents seen by every instance.
   function automatic logic [31:0] mem_word(input logic [63:0] a);
      case (a)
         64'h0:   mem_word = 32'h1000_0913;
         64'h4:   mem_word = 32'h0070_0993;
         64'h8:   mem_word = 32'h0734_0663;
         default: mem_word = 32'hC000_0000 | a[31:0];
      endcase
   endfunction

   // ---------------- instance 0: defaults ----------------
   logic        rst0, stall0, br0;
   logic [63:0] tgt0, addr0, ifpc0;
   logic [31:0] data0, inst0;
   logic        vld0, mis0;
   logic [31:0] cnt0;
   assign data0 = mem_word(addr0);
   instruction_fetch_stage u0 (
      .clk(clk), .reset(rst0), .stall(stall0), .branch_taken(br0), .branch_target(tgt0),
      .inst_addr(addr0), .inst_data(data0), .if_id_pc(ifpc0), .if_id_inst(inst0),
      .if_id_valid(vld0), .misaligned(mis0), .fetch_count(cnt0));

   // ---------------- instance 1: reset PC at top of address space ----------------
   logic        rst1, stall1, br1;
   logic [63:0] tgt1, addr1, ifpc1;
   logic [31:0] data1, inst1;
   logic        vld1, mis1;
   logic [31:0] cnt1;
   assign data1 = mem_word(addr1);
   instruction_fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u1 (
      .clk(clk), .reset(rst1), .stall(stall1), .branch_taken(br1), .branch_target(tgt1),
      .inst_addr(addr1), .inst_data(data1), .if_id_pc(ifpc1), .if_id_inst(inst1),
      .if_id_valid(vld1), .misaligned(mis1), .fetch_count(cnt1));

   // ---------------- instance 2: 4-bit counter ----------------
   logic        rst2, stall2, br2;
   logic [63:0] tgt2, addr2, ifpc2;
   logic [31:0] data2, inst2;
   logic        vld2, mis2;
   logic [3:0]  cnt2;
   assign data2 = mem_word(addr2);
   instruction_fetch_stage #(.CNT_W(4)) u2 (
      .clk(clk), .reset(rst2), .stall(stall2), .branch_taken(br2), .branch_target(tgt2),
      .inst_addr(addr2), .inst_data(data2), .if_id_pc(ifpc2), .if_id_inst(inst2),
      .if_id_valid(vld2), .misaligned(mis2), .fetch_count(cnt2));

   // ---------------- vectors and scoreboard ----------------
   typedef struct {
      logic        rst, stall, br;
      logic [63:0] tgt;
      logic [63:0] e_pc, e_ifpc;
      logic [31:0] e_inst;
      logic        e_vld, e_mis;
      logic [63:0] e_cnt;
   } vec_t;

   typedef struct {
      int          id;
      int          step;
      logic [63:0] e_pc, e_ifpc;
      logic [31:0] e_inst;
      logic        e_vld, e_mis;
      logic [63:0] e_cnt;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   function automatic vec_t mk(input logic rst, input logic stall, input logic br,
                               input logic [63:0] tgt, input logic [63:0] pc,
                               input logic [63:0] ifpc, input logic [31:0] inst,
                               input logic vld, input logic mis, input logic [63:0] cnt);
      vec_t v;
      v.rst = rst; v.stall = stall; v.br = br; v.tgt = tgt;
      v.e_pc = pc; v.e_ifpc = ifpc; v.e_inst = inst; v.e_vld = vld; v.e_mis = mis; v.e_cnt = cnt;
      return v;
   endfunction

   task automatic cmp(input int id, input int step, input string nm,
                      input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL dut%0d step%0d %s: got %h expected %h", id, step, nm, act, exp);
      end
   endtask

   // Drive one instance's inputs and queue what it must show after the next edge.
   task automatic drive(input int id, input int step, input vec_t v);
      exp_t e;
      case (id)
         0: begin rst0 = v.rst; stall0 = v.stall; br0 = v.br; tgt0 = v.tgt; end
         1: begin rst1 = v.rst; stall1 = v.stall; br1 = v.br; tgt1 = v.tgt; end
         default: begin rst2 = v.rst; stall2 = v.stall; br2 = v.br; tgt2 = v.tgt; end
      endcase
      e.id = id; e.step = step;
      e.e_pc = v.e_pc; e.e_ifpc = v.e_ifpc; e.e_inst = v.e_inst;
      e.e_vld = v.e_vld; e.e_mis = v.e_mis; e.e_cnt = v.e_cnt;
      sb.push_back(e);
   endtask

   // Advance one edge and check every queued expectation #1 after it.
   task automatic step_and_check();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.id)
            0: begin
               cmp(0, e.step, "inst_addr", addr0, e.e_pc);
               cmp(0, e.step, "if_id_pc", ifpc0, e.e_ifpc);
               cmp(0, e.step, "if_id_inst", {32'h0, inst0}, {32'h0, e.e_inst});
               cmp(0, e.step, "if_id_valid", {63'h0, vld0}, {63'h0, e.e_vld});
               cmp(0, e.step, "misaligned", {63'h0, mis0}, {63'h0, e.e_mis});
               cmp(0, e.step, "fetch_count", {32'h0, cnt0}, e.e_cnt);
            end
            1: begin
               cmp(1, e.step, "inst_addr", addr1, e.e_pc);
               cmp(1, e.step, "if_id_pc", ifpc1, e.e_ifpc);
               cmp(1, e.step, "if_id_inst", {32'h0, inst1}, {32'h0, e.e_inst});
               cmp(1, e.step, "if_id_valid", {63'h0, vld1}, {63'h0, e.e_vld});
               cmp(1, e.step, "misaligned", {63'h0, mis1}, {63'h0, e.e_mis});
               cmp(1, e.step, "fetch_count", {32'h0, cnt1}, e.e_cnt);
            end
            default: begin
               cmp(2, e.step, "inst_addr", addr2, e.e_pc);
               cmp(2, e.step, "if_id_pc", ifpc2, e.e_ifpc);
               cmp(2, e.step, "if_id_inst", {32'h0, inst2}, {32'h0, e.e_inst});
               cmp(2, e.step, "if_id_valid", {63'h0, vld2}, {63'h0, e.e_vld});
               cmp(2, e.step, "misaligned", {63'h0, mis2}, {63'h0, e.e_mis});
               cmp(2, e.step, "fetch_count", {60'h0, cnt2}, e.e_cnt);
            end
         endcase
      end
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

   vec_t tbl[21];

   initial begin
      rst0 = 1'b1; stall0 = 1'b0; br0 = 1'b0; tgt0 = 64'h0;
      rst1 = 1'b1; stall1 = 1'b0; br1 = 1'b0; tgt1 = 64'h0;
      rst2 = 1'b1; stall2 = 1'b0; br2 = 1'b0; tgt2 = 64'h0;

      //            rst stl br  tgt       pc        ifpc   inst                vld mis cnt
      tbl[0]  = mk(1, 0, 0, 64'h0,  64'h0,  64'h0,  NOP,               0, 0, 0);
      tbl[1]  = mk(0, 0, 0, 64'h0,  64'h4,  64'h0,  32'h1000_0913,     1, 0, 1);
      tbl[2]  = mk(0, 0, 0, 64'h0,  64'h8,  64'h4,  32'h0070_0993,     1, 0, 2);
      tbl[3]  = mk(0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h0070_0993,     1, 0, 2);
      tbl[4]  = mk(0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h0070_0993,     1, 0, 2);
      tbl[5]  = mk(0, 1, 0, 64'h0,  64'h8,  64'h4,  32'h0070_0993,     1, 0, 2);
      tbl[6]  = mk(0, 0, 0, 64'h0,  64'hC,  64'h8,  32'h0734_0663,     1, 0, 3);
      tbl[7]  = mk(0, 0, 0, 64'h0,  64'h10, 64'hC,  mem_word(64'hC),   1, 0, 4);
      tbl[8]  = mk(0, 0, 0, 64'h0,  64'h14, 64'h10, mem_word(64'h10),  1, 0, 5);
      tbl[9]  = mk(0, 0, 0, 64'h0,  64'h18, 64'h14, mem_word(64'h14),  1, 0, 6);
      tbl[10] = mk(0, 0, 0, 64'h0,  64'h1C, 64'h18, mem_word(64'h18),  1, 0, 7);
      // branch with simultaneous stall at pc=0x1C: branch wins, bubble
      tbl[11] = mk(0, 1, 1, 64'h68, 64'h68, 64'h0,  NOP,               0, 0, 7);
      tbl[12] = mk(0, 0, 0, 64'h0,  64'h6C, 64'h68, mem_word(64'h68),  1, 0, 8);
      // misaligned target: halt, pc frozen at 0x6C
      tbl[13] = mk(0, 0, 1, 64'h6A, 64'h6C, 64'h0,  NOP,               0, 1, 8);
      tbl[14] = mk(0, 0, 0, 64'h0,  64'h6C, 64'h0,  NOP,               0, 1, 8);
      tbl[15] = mk(0, 0, 1, 64'h0,  64'h6C, 64'h0,  NOP,               0, 1, 8);
      tbl[16] = mk(0, 1, 0, 64'h0,  64'h6C, 64'h0,  NOP,               0, 1, 8);
      // reset out of halt (with stall asserted), fetching restarts at 0
      tbl[17] = mk(1, 1, 0, 64'h0,  64'h0,  64'h0,  NOP,               0, 0, 0);
      tbl[18] = mk(0, 0, 0, 64'h0,  64'h4,  64'h0,  32'h1000_0913,     1, 0, 1);
      tbl[19] = mk(0, 1, 0, 64'h0,  64'h4,  64'h0,  32'h1000_0913,     1, 0, 1);
      tbl[20] = mk(1, 1, 0, 64'h0,  64'h0,  64'h0,  NOP,               0, 0, 0);

      for (int i = 0; i < 21; i++) begin
         drive(0, i, tbl[i]);
         step_and_check();
      end
      rst0 = 1'b1;

      // Reset PC at the top of the address space: pc+4 wraps to 0.
      drive(1, 0, mk(1, 0, 0, 64'h0, TOP,   64'h0, NOP,              0, 0, 0));
      step_and_check();
      drive(1, 1, mk(0, 0, 0, 64'h0, 64'h0, TOP,   mem_word(TOP),    1, 0, 1));
      step_and_check();
      drive(1, 2, mk(0, 0, 0, 64'h0, 64'h4, 64'h0, 32'h1000_0913,    1, 0, 2));
      step_and_check();
      rst1 = 1'b1;

      // 4-bit counter saturates at 15 over 20 deliveries.
      drive(2, 0, mk(1, 0, 0, 64'h0, 64'h0, 64'h0, NOP, 0, 0, 0));
      step_and_check();
      for (int k = 1; k <= 20; k++) begin
         drive(2, k, mk(0, 0, 0, 64'h0, 64'(4 * k), 64'(4 * (k - 1)),
                        mem_word(64'(4 * (k - 1))), 1, 0, (k > 15) ? 64'd15 : 64'(k)));
         step_and_check();
      end
      drive(2, 21, mk(0, 1, 0, 64'h0, 64'd80, 64'd76, mem_word(64'd76), 1, 0, 15));
      step_and_check();
      // reset asserted mid-stall
      drive(2, 22, mk(1, 1, 0, 64'h0, 64'h0, 64'h0, NOP, 0, 0, 0));
      step_and_check();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
PC register and IF/ID pipeline register for the RISC-V CA processor, directly upstream of the instruction memory. It drives the 64-bit byte address into the combinational instruction memory and captures the returned 32-bit word into the IF/ID register. It also handles stall, branch redirect/flush, misaligned-target fault halt and a count of delivered instructions.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset
NOP_INST, 32'h00000013, word inserted into IF/ID on flush/reset (addi x0,x0,0)
CNT_W, 32, width of the delivered-instruction counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; hold PC and IF/ID
branch_taken  input  1  redirect request from EX/MEM (PCSrc)
branch_target  input  64  redirect byte address
inst_addr  output  64  byte address to instruction memory (combinational copy of PC)
inst_data  input  32  instruction word returned by memory for inst_addr
if_id_pc  output  64  PC of the instruction held in IF/ID
if_id_inst  output  32  instruction held in IF/ID
if_id_valid  output  1  IF/ID holds a real instruction
misaligned  output  1  sticky fault: branch target not word aligned
fetch_count  output  CNT_W  number of instructions delivered into IF/ID (saturating)

Behaviour:
- One clock; reset is synchronous and active-high. All state updates on rising clk.
- inst_addr = pc at all times (no register between them). The instruction memory is combinational, so inst_data is valid in the same cycle.
- Reset (highest priority, overrides stall/branch, including mid-stall or mid-halt):
  - pc=RESET_PC, state=RUN
  - if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0
  - misaligned=0, fetch_count=0
- FSM states: RUN, HALT. RUN->HALT on branch_taken with branch_target[1:0]!=0. HALT->RUN only via reset.
- RUN, per-cycle priority is branch_taken, then stall, then normal.
  - branch_taken, aligned target: pc<=branch_target. Flush IF/ID: if_id_inst<=NOP_INST, if_id_valid<=0, if_id_pc<=0. Stall is ignored in the same cycle. Count is unchanged.
  - branch_taken, misaligned target: misaligned<=1, state<=HALT, pc unchanged. IF/ID is flushed as above.
  - stall (no branch): pc, IF/ID and count all hold.
  - normal: if_id_pc<=pc, if_id_inst<=inst_data, if_id_valid<=1, pc<=pc+4. fetch_count increments and saturates at all-ones.
- HALT: pc frozen; IF/ID forced to NOP_INST/valid 0/pc 0; branch_taken and stall are ignored; misaligned stays 1.
- Latency: the word at address A appears on if_id_inst one edge after pc==A in a non-stalled, non-branch cycle.
- Arithmetic: pc+4 is modulo 2^64, so 64'hFFFFFFFFFFFFFFFC wraps to 0 with no flag. pc[1:0] stays 0 after reset, provided RESET_PC is aligned.
- Simultaneous stall+branch_taken: the branch wins, because a stalled wrong-path instruction is discarded.
- No combinational path from inputs to registered outputs. Only inst_addr is combinational, and it depends on pc only.

Test Plan:
- Reset then free-run with memory word 0x10000913@0, 0x00700993@4, 0x07340663@8. Expected:
  - inst_addr 0,4,8 on successive cycles
  - IF/ID shows (0,0x10000913,1) then (4,0x00700993,1)
  - fetch_count 1,2,3
- Stall held 3 cycles while pc=8. Expected: inst_addr stays 8, IF/ID stays (4,0x00700993,1), count frozen. Release: next edge gives (8,0x07340663), pc=12.
- branch_taken=1, target=0x68, stall=1 in the same cycle with pc=0x1C. Expected:
  - next cycle: pc=0x68, IF/ID=(0,0x00000013,0), count unchanged
  - following edge: IF/ID pc=0x68
- branch_taken with target=0x6A. Expected:
  - misaligned=1, pc stays at its prior value
  - IF/ID valid 0 forever
  - later branch_taken target=0x0 has no effect
  - reset clears misaligned and restarts fetching at 0
- RESET_PC=64'hFFFFFFFFFFFFFFFC, one normal cycle. Expected: if_id_pc=FFFF_FFFF_FFFF_FFFC, then pc=0.
- CNT_W=4, run 20 normal cycles. Expected: fetch_count saturates at 4'hF. Reset asserted mid-stall returns all outputs to their reset values on the next edge.
